seq_logic_unit: RTL

- Parametrised, multicycle bitwise logic unit for the ALU datapath.
- Processes a WIDTH-bit operand pair one SLICE-bit slice per clock, least-significant slice first.
- Provides eight logic modes, a start/busy/done handshake, a held result and a zero flag.
- Sits beside the multiplier as the ALU's logic-op engine, so logic and multiply ops share the same handshake style.

---
 rtl/seq_logic_pkg.sv | 5 +
 rtl/logic_slice.sv | 18 +
 rtl/seq_logic_unit.sv | 66 ++++++
 3 files changed

// File: rtl/seq_logic_pkg.sv
// seq_logic_pkg: op codes and FSM state encoding shared by the sequential logic unit
package seq_logic_pkg;
  typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOTA, OP_PASSA} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
endpackage

// File: rtl/logic_slice.sv
// logic_slice: combinational bitwise op y = f(op, a, b) over one SLICE-bit slice
module logic_slice import seq_logic_pkg::*; #(
  parameter int SLICE = 4
) (
  input  op_e              op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);
  always_comb
    y = op == OP_AND  ? a & b :
        op == OP_OR   ? a | b :
        op == OP_XOR  ? a ^ b :
        op == OP_XNOR ? ~(a ^ b) :
        op == OP_NAND ? ~(a & b) :
        op == OP_NOR  ? ~(a | b) :
        op == OP_NOTA ? ~a : a;
endmodule

// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multicycle bitwise logic unit, one SLICE per clock LSB-first, start/busy/done handshake
module seq_logic_unit import seq_logic_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_e state, state_n;
  op_e op_q;
  logic [WIDTH-1:0] a_q, b_q, res_n;
  logic [SLICE-1:0] y;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(NSLICE - 1);
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  logic_slice #(.SLICE(SLICE)) u_slice (
    .op(op_q),
    .a(a_q[cnt*SLICE +: SLICE]),
    .b(b_q[cnt*SLICE +: SLICE]),
    .y(y)
  );
  always_comb begin
    res_n = result;
    res_n[cnt*SLICE +: SLICE] = y;
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = ST_EXEC;
      ST_EXEC: if (last) state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      cnt <= '0;
      result <= '0;
      zero <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_AND;
    end else if (state == ST_IDLE && start) begin
      a_q <= a;
      b_q <= b;
      op_q <= op_e'(op);
      result <= '0;
      cnt <= '0;
    end else if (state == ST_EXEC) begin
      result <= res_n;
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) zero <= res_n == '0;
    end
endmodule
